// File: rtl/gcd_engine.sv
// gcd_engine: streaming GCD of two WIDTH-bit unsigned operands with a
// valid/ready input channel, a valid/ready result channel and a saturating
// per-job iteration count.
// Optional build macro GCD_STEIN_EN selects the binary (Stein) algorithm;
// when it is undefined the engine uses subtractive Euclid.
module gcd_engine #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ITER_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_in_valid,
   input  logic [2*WIDTH-1:0]   io_in_data,
   output logic                 io_in_ready,
   output logic                 io_out_valid,
   input  logic                 io_out_ready,
   output logic [WIDTH-1:0]     io_out_data,
   output logic [ITER_W-1:0]    io_out_iters
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

`ifdef GCD_STEIN_EN
   // k counts common factors of two; it never exceeds WIDTH-1
   localparam int unsigned K_W = $clog2(WIDTH) + 1;
`endif

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    x_q, x_d;
   logic [WIDTH-1:0]    y_q, y_d;
   logic [ITER_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]    res_q, res_d;
   logic [ITER_W-1:0]   iters_q, iters_d;
   logic [ITER_W-1:0]   iter_inc;
`ifdef GCD_STEIN_EN
   logic [K_W-1:0]      k_q, k_d;
`endif

   // Handshake flags are pure decodes of the registered state
   assign io_in_ready  = (state_q == IDLE);
   assign io_out_valid = (state_q == DONE);
   assign io_out_data  = res_q;
   assign io_out_iters = iters_q;

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         iters_q <= '0;
`ifdef GCD_STEIN_EN
         k_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         iters_q <= iters_d;
`ifdef GCD_STEIN_EN
         k_q     <= k_d;
`endif
      end
   end

   // Next-state and datapath step; one algorithm step per BUSY cycle
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      iters_d  = iters_q;
`ifdef GCD_STEIN_EN
      k_d      = k_q;
`endif
      iter_inc = (cnt_q == {ITER_W{1'b1}}) ? cnt_q : cnt_q + ITER_W'(1);

      unique case (state_q)
         IDLE: begin
            if (io_in_valid) begin
               x_d     = io_in_data[WIDTH-1:0];
               y_d     = io_in_data[2*WIDTH-1:WIDTH];
               cnt_d   = '0;
`ifdef GCD_STEIN_EN
               k_d     = '0;
`endif
               state_d = BUSY;
            end
         end

         BUSY: begin
            cnt_d = iter_inc;
            if ((x_q == '0) || (y_q == '0)) begin
`ifdef GCD_STEIN_EN
               res_d = (x_q | y_q) << k_q;
`else
               res_d = x_q | y_q;
`endif
               iters_d = iter_inc;
               state_d = DONE;
            end else begin
`ifdef GCD_STEIN_EN
               if (!x_q[0] && !y_q[0]) begin
                  x_d = x_q >> 1;
                  y_d = y_q >> 1;
                  k_d = k_q + K_W'(1);
               end else if (!x_q[0]) begin
                  x_d = x_q >> 1;
               end else if (!y_q[0]) begin
                  y_d = y_q >> 1;
               end else if (x_q > y_q) begin
                  x_d = x_q - y_q;
               end else begin
                  y_d = y_q - x_q;
               end
`else
               if (x_q > y_q) begin
                  x_d = y_q;
                  y_d = x_q;
               end else begin
                  y_d = y_q - x_q;
               end
`endif
            end
         end

         DONE: begin
            if (io_out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: randomized scoreboard bench for gcd_engine.
module tb_gcd_engine;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned ITER_W = 8;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 io_in_valid = 1'b0;
   logic [2*WIDTH-1:0]   io_in_data = '0;
   logic                 io_in_ready;
   logic                 io_out_valid;
   logic                 io_out_ready = 1'b0;
   logic [WIDTH-1:0]     io_out_data;
   logic [ITER_W-1:0]    io_out_iters;

   gcd_engine #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .io_in_valid  (io_in_valid),
      .io_in_data   (io_in_data),
      .io_in_ready  (io_in_ready),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_out_data  (io_out_data),
      .io_out_iters (io_out_iters)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint g;
      longint it;
      int     hs;
      longint true_it;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 0;
   bit   prev_valid = 0;
   bit   after_hs = 0;
   logic [WIDTH-1:0]  last_data = '0;
   logic [ITER_W-1:0] last_iters = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference gcd by remainder Euclid
   function automatic longint ref_gcd(input longint a, input longint b);
      longint t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Step count of the subtractive procedure, counting the terminating step
   function automatic longint ref_iters(input longint a, input longint b);
      longint n = 0;
      longint t;
      forever begin
         n++;
         if (a == 0 || b == 0) break;
         if (a > b) begin
            t = a; a = b; b = t;
         end else begin
            b = b - a;
         end
      end
      return n;
   endfunction

   // Downstream ready pattern
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       io_out_ready = 1'b1;
         1:       io_out_ready = 1'($urandom_range(0, 1));
         default: io_out_ready = 1'b0;
      endcase
   end

   // Monitor: pops the scoreboard on each new result and checks hold behaviour
   always @(negedge clk) begin
      if (!reset) begin
         if (after_hs) begin
            check("post_hs_in_ready", 64'(io_in_ready), 64'd1);
            check("post_hs_out_valid", 64'(io_out_valid), 64'd0);
            check("idle_keeps_data", 64'(io_out_data), 64'(last_data));
            check("idle_keeps_iters", 64'(io_out_iters), 64'(last_iters));
            after_hs = 0;
         end
         if (io_out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got data %0d expected no output", io_out_data);
            end else begin
               cur = sb.pop_front();
               check("out_data", 64'(io_out_data), 64'(cur.g));
`ifndef GCD_STEIN_EN
               check("out_iters", 64'(io_out_iters), 64'(cur.it));
               check("latency", 64'(cyc - cur.hs), 64'(cur.true_it));
`endif
            end
            last_data  = io_out_data;
            last_iters = io_out_iters;
         end else if (io_out_valid) begin
            check("held_data", 64'(io_out_data), 64'(last_data));
            check("held_iters", 64'(io_out_iters), 64'(last_iters));
            check("held_in_ready", 64'(io_in_ready), 64'd0);
         end
         if (io_out_valid && io_out_ready) after_hs = 1;
         prev_valid = io_out_valid;
      end else begin
         prev_valid = 0;
         after_hs   = 0;
      end
   end

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (!io_in_ready && n < 80000) begin
         @(negedge clk);
         n++;
      end
      if (!io_in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready 0 expected 1");
         return;
      end
      e.g       = ref_gcd(longint'(a), longint'(b));
      e.true_it = ref_iters(longint'(a), longint'(b));
      e.it      = (e.true_it > 255) ? 255 : e.true_it;
      e.hs      = cyc + 1;
      sb.push_back(e);
      io_in_valid = 1'b1;
      io_in_data  = {b, a};
      @(posedge clk);
      #1;
      io_in_valid = 1'b0;
      io_in_data  = (2*WIDTH)'($urandom);
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((sb.size() != 0 || io_out_valid) && n < max) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      int n;

      // Reset state
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(io_in_ready), 64'd1);
      check("rst_out_valid", 64'(io_out_valid), 64'd0);
      check("rst_out_data", 64'(io_out_data), 64'd0);
      check("rst_out_iters", 64'(io_out_iters), 64'd0);
      reset = 1'b0;
      ready_mode = 0;

      // Directed: gcd(12,8)
      send(16'd12, 16'd8);
      drain(200);
      check("gcd_12_8", 64'(last_data), 64'd4);
`ifndef GCD_STEIN_EN
      check("iters_12_8", 64'(last_iters), 64'd6);
`endif

      // Zero operands
      send(16'd0, 16'd0);
      drain(50);
      check("gcd_0_0", 64'(last_data), 64'd0);
      check("iters_0_0", 64'(last_iters), 64'd1);
      send(16'd9, 16'd0);
      drain(50);
      check("gcd_9_0", 64'(last_data), 64'd9);
      check("iters_9_0", 64'(last_iters), 64'd1);
      send(16'd0, 16'd7);
      drain(50);
      check("gcd_0_7", 64'(last_data), 64'd7);
      check("iters_0_7", 64'(last_iters), 64'd1);

      // Iteration counter saturation
      send(16'd1, 16'd65535);
      drain(70000);
      check("gcd_1_65535", 64'(last_data), 64'd1);
`ifndef GCD_STEIN_EN
      check("iters_saturate", 64'(last_iters), 64'd255);
`endif

      // Backpressure hold
      ready_mode = 2;
      send(16'd14, 16'd21);
      n = 0;
      while (!io_out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_valid", 64'(io_out_valid), 64'd1);
         check("bp_data", 64'(io_out_data), 64'd7);
         check("bp_in_ready", 64'(io_in_ready), 64'd0);
      end
      ready_mode = 0;
      drain(50);

      // Reset while BUSY drops the job
      send(16'd999, 16'd1000);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_out_valid", 64'(io_out_valid), 64'd0);
      check("midrst_in_ready", 64'(io_in_ready), 64'd1);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      send(16'd24, 16'd18);
      drain(200);
      check("gcd_24_18", 64'(last_data), 64'd6);

      // Randomized jobs with random backpressure
      ready_mode = 1;
      for (int j = 0; j < 120; j++) begin
         a = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, 255));
         b = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, 255));
         send(a, b);
      end
      drain(5000);
      ready_mode = 0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
